// File: rtl/aes_nibble_pkg.sv
// Shared constants and FSM state type for the nibble-serial <-> 128-bit AES block link.
// Both the receive-side deserializer and the transmit-side serializer use these.
package aes_nibble_pkg;

  localparam int NIB_W   = 4;
  localparam int NIBBLES = 32;
  localparam int BLK_W   = NIB_W * NIBBLES;
  localparam int CNT_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/aes_nibble_shreg.sv
// Nibble-wide shift register with selectable load direction and synchronous clear.
// next_o exposes the post-shift word so the owner can capture the final nibble in the same cycle.
module aes_nibble_shreg
  import aes_nibble_pkg::*;
#(
  parameter int W         = BLK_W,
  parameter int NW        = NIB_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  input  logic [NW-1:0] din_i,
  output logic [W-1:0]  next_o
);

  logic [W-1:0] sr_q, sr_d;

  // MSB_FIRST pushes toward the top so the oldest nibble ends up in the high bits.
  always_comb begin
    if (MSB_FIRST) next_o = {sr_q[W-NW-1:0], din_i};
    else           next_o = {din_i, sr_q[W-1:NW]};
  end

  always_comb begin
    sr_d = sr_q;
    if (clr_i)     sr_d = '0;
    else if (en_i) sr_d = next_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

endmodule

// File: rtl/aes_nibble_rx.sv
// Reassembles a framed 4-bit nibble stream into one 128-bit AES block on a valid/ready port,
// flagging frames that end early (err_short) or run past a full block (err_long).
module aes_nibble_rx #(
  parameter int NIB_W     = aes_nibble_pkg::NIB_W,
  parameter int NIBBLES   = aes_nibble_pkg::NIBBLES,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     nib_valid,
  input  logic [NIB_W-1:0]         nib_data,
  input  logic                     nib_last,
  output logic                     nib_ready,
  output logic                     blk_valid,
  output logic [NIB_W*NIBBLES-1:0] blk_data,
  input  logic                     blk_ready,
  output logic                     err_short,
  output logic                     err_long
);

  import aes_nibble_pkg::*;

  localparam int            BW       = NIB_W * NIBBLES;
  localparam int            CW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NIBBLES - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          blk_valid_q, blk_valid_d;
  logic [BW-1:0] blk_data_q, blk_data_d;
  logic          err_short_q, err_short_d;
  logic          err_long_q, err_long_d;
  logic          xfer, handoff, sh_en, sh_clr;
  logic [BW-1:0] sh_next;

  // While a block waits in FULL the link stalls; DRAIN keeps accepting so overrun data is flushed.
  assign nib_ready = (state_q == FULL) ? blk_ready : 1'b1;
  assign xfer      = nib_valid && nib_ready;
  assign handoff   = blk_valid_q && blk_ready;

  aes_nibble_shreg #(
    .W         (BW),
    .NW        (NIB_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (sh_en),
    .clr_i  (sh_clr),
    .din_i  (nib_data),
    .next_o (sh_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_valid_d = blk_valid_q;
    blk_data_d  = blk_data_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    sh_en       = 1'b0;
    sh_clr      = 1'b0;
    case (state_q)
      COLLECT: begin
        if (xfer) begin
          if (cnt_q == CNT_LAST) begin
            blk_data_d  = sh_next;
            blk_valid_d = 1'b1;
            cnt_d       = '0;
            sh_clr      = 1'b1;
            if (nib_last) begin
              state_d = FULL;
            end else begin
              err_long_d = 1'b1;
              state_d    = DRAIN;
            end
          end else if (nib_last) begin
            err_short_d = 1'b1;
            cnt_d       = '0;
            sh_clr      = 1'b1;
          end else begin
            sh_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        // A nibble accepted alongside the handoff opens the next block with no bubble.
        if (handoff) begin
          blk_valid_d = 1'b0;
          state_d     = COLLECT;
          if (xfer) begin
            if (nib_last) begin
              err_short_d = 1'b1;
              cnt_d       = '0;
              sh_clr      = 1'b1;
            end else begin
              sh_en = 1'b1;
              cnt_d = CW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (handoff) blk_valid_d = 1'b0;
        if (xfer && nib_last) state_d = (blk_valid_q && !handoff) ? FULL : COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      blk_valid_q <= 1'b0;
      blk_data_q  <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_valid_q <= blk_valid_d;
      blk_data_q  <= blk_data_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

  assign blk_valid = blk_valid_q;
  assign blk_data  = blk_data_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_aes_nibble_rx.sv
// Directed bench for aes_nibble_rx: a scoreboard queue of expected blocks is popped on every handoff;
// a second instance with MSB_FIRST=0 receives identical stimulus to cover the reversed packing.
module tb_aes_nibble_rx;

  logic         clk;
  logic         rst_n;
  logic         nib_valid;
  logic [3:0]   nib_data;
  logic         nib_last;
  logic         blk_ready;
  logic         nib_ready, blk_valid, err_short, err_long;
  logic [127:0] blk_data;
  logic         nib_ready_l, blk_valid_l, err_short_l, err_long_l;
  logic [127:0] blk_data_l;

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           n_short = 0;
  int           n_long = 0;
  int           hcyc;
  logic [3:0]   frame [40];
  logic [127:0] sb [$];
  logic [127:0] exp1;

  aes_nibble_rx #(.NIB_W(4), .NIBBLES(32), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .nib_valid(nib_valid), .nib_data(nib_data), .nib_last(nib_last),
    .nib_ready(nib_ready), .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
    .err_short(err_short), .err_long(err_long)
  );

  aes_nibble_rx #(.NIB_W(4), .NIBBLES(32), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .nib_valid(nib_valid), .nib_data(nib_data), .nib_last(nib_last),
    .nib_ready(nib_ready_l), .blk_valid(blk_valid_l), .blk_data(blk_data_l), .blk_ready(blk_ready),
    .err_short(err_short_l), .err_long(err_long_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Scoreboard and pulse bookkeeping, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (blk_valid && blk_ready) begin
        chk1("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) chk("sb_block", blk_data, sb.pop_front());
      end
      if (err_short) n_short++;
      if (err_long) n_long++;
      chk1("err_no_overlap", err_short & err_long, 1'b0);
      chk("lsb_ctrl_match", 128'({nib_ready_l, blk_valid_l, err_short_l, err_long_l}),
          128'({nib_ready, blk_valid, err_short, err_long}));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    int w;
    w = 0;
    nib_valid = 1'b1;
    nib_data  = d;
    nib_last  = l;
    @(negedge clk);
    while (nib_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk1("nib_ready_wait", nib_ready, 1'b1);
    step();
    nib_valid = 1'b0;
    nib_last  = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) send(frame[i], i == n - 1);
  endtask

  function automatic logic [127:0] pack(input bit msb);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (msb) r[4*(31-i) +: 4] = frame[i];
      else     r[4*i +: 4]      = frame[i];
    end
    return r;
  endfunction

  initial begin
    rst_n     = 1'b0;
    nib_valid = 1'b0;
    nib_data  = 4'h0;
    nib_last  = 1'b0;
    blk_ready = 1'b1;
    exp1      = 128'h0123456789ABCDEF0123456789ABCDEF;

    // Reset state
    #3;
    chk1("rst_blk_valid", blk_valid, 1'b0);
    chk("rst_blk_data", blk_data, 128'd0);
    chk1("rst_err_short", err_short, 1'b0);
    chk1("rst_err_long", err_long, 1'b0);
    chk1("rst_nib_ready", nib_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // T1: 0..F,0..F, MSB first, blk_ready held high
    for (int i = 0; i < 32; i++) frame[i] = 4'(i % 16);
    sb.push_back(exp1);
    send_frame(32);
    @(negedge clk);
    chk1("t1_blk_valid", blk_valid, 1'b1);
    chk("t1_blk_data", blk_data, exp1);
    chk("t1_blk_data_lsb", blk_data_l, pack(1'b0));
    chk1("t1_err_short", err_short, 1'b0);
    chk1("t1_err_long", err_long, 1'b0);
    step();
    @(negedge clk);
    chk1("t1_blk_valid_cleared", blk_valid, 1'b0);
    step();

    // T2: backpressure for 5 cycles with the next frame offered, then zero-bubble handoff
    blk_ready = 1'b0;
    sb.push_back(exp1);
    send_frame(32);
    @(negedge clk);
    chk1("t2_blk_valid", blk_valid, 1'b1);
    step();
    for (int i = 0; i < 32; i++) frame[i] = 4'(15 - (i % 16));
    sb.push_back(pack(1'b1));
    nib_valid = 1'b1;
    nib_data  = frame[0];
    nib_last  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("t2_stall_nib_ready", nib_ready, 1'b0);
      chk("t2_stall_blk_data", blk_data, exp1);
      step();
    end
    blk_ready = 1'b1;
    @(negedge clk);
    chk1("t2_handoff_nib_ready", nib_ready, 1'b1);
    hcyc = cyc;
    step();
    for (int i = 1; i < 32; i++) send(frame[i], i == 31);
    @(negedge clk);
    chk1("t2_blk2_valid", blk_valid, 1'b1);
    chk("t2_blk2_latency", 128'(cyc - hcyc), 128'd32);
    chk("t2_blk2_data", blk_data, 128'hFEDCBA9876543210FEDCBA9876543210);
    chk("t2_blk2_data_lsb", blk_data_l, pack(1'b0));
    step();

    // T3: short frame of 10, then a full all-A frame
    for (int i = 0; i < 10; i++) frame[i] = 4'h3;
    send_frame(10);
    @(negedge clk);
    chk1("t3_err_short", err_short, 1'b1);
    chk1("t3_no_blk", blk_valid, 1'b0);
    step();
    @(negedge clk);
    chk1("t3_err_short_one_cycle", err_short, 1'b0);
    step();
    for (int i = 0; i < 32; i++) frame[i] = 4'hA;
    sb.push_back({32{4'hA}});
    send_frame(32);
    @(negedge clk);
    chk1("t3_blk_valid", blk_valid, 1'b1);
    chk("t3_blk_data", blk_data, {32{4'hA}});
    step();

    // T4: 35-nibble overrun frame
    for (int i = 0; i < 35; i++) frame[i] = 4'(i % 16);
    sb.push_back(exp1);
    for (int i = 0; i < 35; i++) begin
      send(frame[i], i == 34);
      if (i == 31) begin
        @(negedge clk);
        chk1("t4_blk_valid", blk_valid, 1'b1);
        chk1("t4_err_long", err_long, 1'b1);
        chk("t4_blk_data", blk_data, exp1);
        step();
      end
    end
    @(negedge clk);
    chk1("t4_err_long_clear", err_long, 1'b0);
    chk1("t4_blk_valid_clear", blk_valid, 1'b0);
    chk("t4_n_long", 128'(n_long), 128'd1);
    chk("t4_n_short", 128'(n_short), 128'd1);
    step();

    // T6: LSB-first packing with 1,2,3,... (also proves T4 left the receiver in COLLECT)
    for (int i = 0; i < 32; i++) frame[i] = 4'((i + 1) % 16);
    sb.push_back(128'h123456789ABCDEF0123456789ABCDEF0);
    send_frame(32);
    @(negedge clk);
    chk1("t6_blk_valid", blk_valid, 1'b1);
    chk("t6_msb_data", blk_data, 128'h123456789ABCDEF0123456789ABCDEF0);
    chk("t6_lsb_nib0", 128'(blk_data_l[3:0]), 128'h1);
    chk("t6_lsb_nib1", 128'(blk_data_l[7:4]), 128'h2);
    chk("t6_lsb_data", blk_data_l, 128'h0FEDCBA9876543210FEDCBA987654321);
    step();

    // T5: reset after 20 nibbles, then a fresh frame
    for (int i = 0; i < 20; i++) send(4'h7, 1'b0);
    rst_n = 1'b0;
    #2;
    chk1("t5_rst_blk_valid", blk_valid, 1'b0);
    chk("t5_rst_blk_data", blk_data, 128'd0);
    chk("t5_rst_blk_data_lsb", blk_data_l, 128'd0);
    chk1("t5_rst_err_short", err_short, 1'b0);
    chk1("t5_rst_err_long", err_long, 1'b0);
    chk1("t5_rst_nib_ready", nib_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 32; i++) frame[i] = 4'(15 - (i % 16));
    sb.push_back(pack(1'b1));
    send_frame(32);
    @(negedge clk);
    chk1("t5_blk_valid", blk_valid, 1'b1);
    chk("t5_blk_data", blk_data, 128'hFEDCBA9876543210FEDCBA9876543210);
    chk("t5_blk_data_lsb", blk_data_l, pack(1'b0));
    step();
    step();

    chk("sb_drained", 128'(sb.size()), 128'd0);
    chk("final_n_short", 128'(n_short), 128'd1);
    chk("final_n_long", 128'(n_long), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
